vram_write_queue: RTL and testbench

- Upstream feeder for the GPU VRAM write port. The CPU may write at any time; VRAM only accepts writes while the GPU reports `writable` (the vblank window).
- The block captures CPU VRAM writes in a FIFO at any time and drains them into the GPU's address/data/write_enable/SELECT_vram inputs, one entry per cycle, only while `writable` is high.
- It reports fill level, overflow, and frames whose window closed before the queue emptied.

---
 rtl/vram_write_queue.sv | 129 ++++++++++++
 tb/tb_vram_write_queue.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_write_queue.sv
// vram_write_queue: buffers CPU VRAM writes at any time and drains them into
// the GPU write port one entry per cycle while the GPU reports `writable`.
// Also reports fill level, dropped pushes and windows that closed early.
module vram_write_queue #(
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 12
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cpu_we,
   input  logic [ADDR_WIDTH-1:0]    cpu_addr,
   input  logic [7:0]               cpu_data,
   input  logic                     flush,
   input  logic                     writable,
   output logic [ADDR_WIDTH-1:0]    vram_address,
   output logic [7:0]               vram_data,
   output logic                     vram_we,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     overflow,
   input  logic                     clr_overflow,
   output logic [7:0]               late_frames,
   output logic                     drained
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   typedef enum logic {S_IDLE, S_DRAIN} state_t;

   logic [ADDR_WIDTH+7:0] mem_q [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic          overflow_q, overflow_d;
   logic [7:0]    late_q, late_d;
   logic          drained_q, drained_d;
   state_t        state_q, state_d;

   logic pop;
   logic push_acc;
   logic push_drop;
   logic is_full;

   // Datapath and handshake toward the GPU; the GPU samples and we pop on the same edge.
   always_comb begin
      is_full      = (count_q == FULL_CNT);
      pop          = (state_q == S_DRAIN) && writable && (count_q != '0) && !flush;
      push_acc     = cpu_we && !flush && (!is_full || pop);
      push_drop    = cpu_we && !flush && is_full && !pop;
      vram_we      = pop;
      vram_address = mem_q[rd_ptr_q][ADDR_WIDTH+7:8];
      vram_data    = mem_q[rd_ptr_q][7:0];
      count        = count_q;
      full         = is_full;
      overflow     = overflow_q;
      late_frames  = late_q;
      drained      = drained_q;
   end

   // Pointer, occupancy, sticky flag and drain-state next values.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      late_d     = late_q;
      drained_d  = 1'b0;
      state_d    = state_q;

      if (clr_overflow) overflow_d = 1'b0;
      if (push_drop)    overflow_d = 1'b1;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         state_d  = S_IDLE;
      end else begin
         if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)      rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + {{PW{1'b0}}, push_acc} - {{PW{1'b0}}, pop};

         case (state_q)
            S_IDLE: begin
               if (writable && ((count_q != '0) || push_acc)) state_d = S_DRAIN;
            end
            S_DRAIN: begin
               if (!writable) begin
                  state_d = S_IDLE;
                  if ((count_q != '0) && (late_q != 8'hFF)) late_d = late_q + 8'd1;
               end else if (count_d == '0) begin
                  state_d   = S_IDLE;
                  drained_d = pop;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Control state registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         late_q     <= '0;
         drained_q  <= 1'b0;
         state_q    <= S_IDLE;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         late_q     <= late_d;
         drained_q  <= drained_d;
         state_q    <= state_d;
      end
   end

   // Entry storage is never reset; only accepted pushes write it.
   always_ff @(posedge clk) begin
      if (push_acc) mem_q[wr_ptr_q] <= {cpu_addr, cpu_data};
   end

endmodule

// File: tb/tb_vram_write_queue.sv
// Bench for vram_write_queue: queue-based reference model plus directed literal checks.
module tb_vram_write_queue;

   localparam int DEPTH = 16;
   localparam int AW    = 12;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [7:0]    cpu_data = '0;
   logic          flush = 1'b0;
   logic          writable = 1'b0;
   logic          clr_overflow = 1'b0;
   logic [AW-1:0] vram_address;
   logic [7:0]    vram_data;
   logic          vram_we;
   logic [$clog2(DEPTH):0] count;
   logic          full;
   logic          overflow;
   logic [7:0]    late_frames;
   logic          drained;

   int errors = 0;
   int checks = 0;

   vram_write_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
      .flush(flush), .writable(writable), .vram_address(vram_address), .vram_data(vram_data),
      .vram_we(vram_we), .count(count), .full(full), .overflow(overflow),
      .clr_overflow(clr_overflow), .late_frames(late_frames), .drained(drained)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: plain queue of pending writes plus window bookkeeping.
   logic [AW+7:0] q[$];
   bit            m_drain;
   bit            m_ovf;
   int            m_late;
   bit            m_drained;

   function automatic bit exp_pop();
      return m_drain && writable && (q.size() != 0) && !flush;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         q.delete();
         m_drain   = 0;
         m_ovf     = 0;
         m_late    = 0;
         m_drained = 0;
      end else begin
         bit we, acc, drop;
         int old_n;
         we    = exp_pop();
         old_n = q.size();
         acc   = cpu_we && !flush && ((old_n != DEPTH) || we);
         drop  = cpu_we && !flush && !acc;
         if (clr_overflow) m_ovf = 0;
         if (drop) m_ovf = 1;
         m_drained = 0;
         if (flush) begin
            q.delete();
            m_drain = 0;
         end else begin
            if (we) void'(q.pop_front());
            if (acc) q.push_back({cpu_addr, cpu_data});
            if (!m_drain) begin
               if (writable && (old_n != 0 || acc)) m_drain = 1;
            end else if (!writable) begin
               m_drain = 0;
               if (old_n != 0 && m_late < 255) m_late++;
            end else if (q.size() == 0) begin
               m_drain   = 0;
               m_drained = we;
            end
         end
      end
   end

   // Compare every cycle, away from the active edge.
   always @(negedge clk) begin
      bit e;
      e = exp_pop();
      chk("vram_we", {31'd0, vram_we}, {31'd0, e});
      if (e) begin
         chk("vram_address", {20'd0, vram_address}, {20'd0, q[0][AW+7:8]});
         chk("vram_data", {24'd0, vram_data}, {24'd0, q[0][7:0]});
      end
      chk("count", {27'd0, count}, q.size());
      chk("full", {31'd0, full}, {31'd0, (q.size() == DEPTH)});
      chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      chk("late_frames", {24'd0, late_frames}, m_late);
      chk("drained", {31'd0, drained}, {31'd0, m_drained});
   end

   task automatic cyc(input bit we, input logic [AW-1:0] a, input logic [7:0] d,
                      input bit wr, input bit fl = 0, input bit clr = 0);
      cpu_we = we; cpu_addr = a; cpu_data = d;
      writable = wr; flush = fl; clr_overflow = clr;
      @(posedge clk); #1;
   endtask

   task automatic window(input int len, output int nwr, output int ndr,
                         output logic [AW+7:0] first, output logic [AW+7:0] third);
      nwr = 0; ndr = 0; first = '0; third = '0;
      for (int i = 0; i < len; i++) begin
         cpu_we = 0; flush = 0; clr_overflow = 0; writable = 1;
         #2;
         if (vram_we) begin
            if (nwr == 0) first = {vram_address, vram_data};
            if (nwr == 2) third = {vram_address, vram_data};
            nwr++;
         end
         if (drained) ndr++;
         @(posedge clk); #1;
      end
      writable = 0;
   endtask

   initial begin
      int nwr, ndr;
      logic [AW+7:0] f, t;
      bit wr;

      // reset state
      #3;
      chk("reset_vram_we", {31'd0, vram_we}, 0);
      chk("reset_count", {27'd0, count}, 0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1;

      // window drain
      cyc(1, 12'h010, 8'hAA, 0);
      cyc(1, 12'h011, 8'hBB, 0);
      cyc(1, 12'h012, 8'hCC, 0);
      cyc(0, 0, 0, 0);
      chk("win_count3", {27'd0, count}, 3);
      chk("win_we_low", {31'd0, vram_we}, 0);
      window(7, nwr, ndr, f, t);
      chk("win_writes", nwr, 3);
      chk("win_first", {12'd0, f}, {12'd0, 12'h010, 8'hAA});
      chk("win_third", {12'd0, t}, {12'd0, 12'h012, 8'hCC});
      chk("win_drained", ndr, 1);
      chk("win_count0", {27'd0, count}, 0);

      // overflow
      for (int i = 0; i < 16; i++) cyc(1, AW'(12'h100 + i), 8'(i), 0);
      chk("ovf_full", {31'd0, full}, 1);
      chk("ovf_before", {31'd0, overflow}, 0);
      cyc(1, 12'hFFF, 8'hEE, 0);
      chk("ovf_set", {31'd0, overflow}, 1);
      cyc(0, 0, 0, 0, 0, 1);
      chk("ovf_clr", {31'd0, overflow}, 0);
      cyc(1, 12'hFFE, 8'hED, 0, 0, 1);
      chk("ovf_set_wins", {31'd0, overflow}, 1);
      chk("ovf_count16", {27'd0, count}, 16);

      // late frame
      window(6, nwr, ndr, f, t);
      cyc(0, 0, 0, 0);
      chk("late_writes", nwr, 5);
      chk("late_count11", {27'd0, count}, 11);
      chk("late_frames1", {24'd0, late_frames}, 1);
      chk("late_nodrain", ndr, 0);
      window(14, nwr, ndr, f, t);
      chk("late_rest", nwr, 11);
      chk("late_drained", ndr, 1);

      // concurrent push/pop at full
      cyc(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 16; i++) cyc(1, AW'($urandom), 8'($urandom), 0);
      cyc(0, 0, 0, 1);
      for (int i = 0; i < 40; i++) cyc(1, AW'($urandom), 8'($urandom), 1);
      chk("conc_count16", {27'd0, count}, 16);
      chk("conc_no_ovf", {31'd0, overflow}, 0);
      for (int i = 0; i < 20; i++) cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 0);

      // flush during drain
      for (int i = 0; i < 10; i++) cyc(1, AW'($urandom), 8'($urandom), 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
      chk("flush_pre8", {27'd0, count}, 8);
      cyc(1, 12'h321, 8'h55, 1, 1);
      chk("flush_count0", {27'd0, count}, 0);
      chk("flush_we0", {31'd0, vram_we}, 0);
      chk("flush_no_ovf", {31'd0, overflow}, 0);
      cyc(0, 0, 0, 0);

      // randomized traffic
      wr = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) == 0) wr = !wr;
         cyc($urandom_range(0, 1) == 1, AW'($urandom), 8'($urandom), wr,
             $urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0);
      end
      cyc(0, 0, 0, 0, 1, 1);

      // asynchronous reset mid-drain
      for (int i = 0; i < 6; i++) cyc(1, AW'($urandom), 8'($urandom), 0);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      #2;
      chk("arst_pre_we", {31'd0, vram_we}, 1);
      rst = 0;
      #1;
      chk("arst_we0", {31'd0, vram_we}, 0);
      chk("arst_count0", {27'd0, count}, 0);
      chk("arst_late0", {24'd0, late_frames}, 0);
      @(posedge clk); #1;
      rst = 1;
      writable = 0;

      // late_frames saturation
      cyc(1, 12'h001, 8'h01, 0);
      cyc(1, 12'h002, 8'h02, 0);
      for (int i = 0; i < 300; i++) begin
         cyc(1, AW'($urandom), 8'($urandom), 0);
         cyc(0, 0, 0, 1);
         cyc(0, 0, 0, 1);
         cyc(0, 0, 0, 0);
      end
      chk("late_sat255", {24'd0, late_frames}, 255);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
